// File: rtl/spi_flash_block_reader_if.sv
// spi_flash_block_reader_if
//   Groups the read-request handshake, the BRAM write port and the four SPI
//   wires of the flash block reader into one bundle.
//   master : the block reader itself (drives busy, strobes, BRAM port, SPI outputs)
//   slave  : the surrounding loader/BRAM/flash (drives the request and MISO)
//   Signals:
//     read_addr[23:0]         flash start byte address, sampled with read_stb
//     read_len[BRAM_AW:0]     byte count, sampled with read_stb; 0 means a full block
//     read_stb                1-cycle start pulse
//     busy                    transaction in progress (incl. CS# recovery)
//     read_done_stb           1-cycle pulse after the last byte was written
//     write_bram_stb          1-cycle BRAM write strobe
//     write_bram_addr         byte index within the block
//     write_bram_data         received byte
//     spi_cs_n/clk/mosi/miso  SPI mode 3 bus
interface spi_flash_block_reader_if #(
  parameter int BRAM_AW = 9
);
  logic [23:0]        read_addr;
  logic [BRAM_AW:0]   read_len;
  logic               read_stb;
  logic               busy;
  logic               read_done_stb;
  logic               write_bram_stb;
  logic [BRAM_AW-1:0] write_bram_addr;
  logic [7:0]         write_bram_data;
  logic               spi_cs_n;
  logic               spi_clk;
  logic               spi_mosi;
  logic               spi_miso;

  modport master (
    input  read_addr, read_len, read_stb, spi_miso,
    output busy, read_done_stb, write_bram_stb, write_bram_addr, write_bram_data,
           spi_cs_n, spi_clk, spi_mosi
  );

  modport slave (
    output read_addr, read_len, read_stb, spi_miso,
    input  busy, read_done_stb, write_bram_stb, write_bram_addr, write_bram_data,
           spi_cs_n, spi_clk, spi_mosi
  );
endinterface

// File: rtl/spi_flash_block_reader.sv
// spi_flash_block_reader
//   Reads a block of bytes from an SPI NOR flash (READ 0x03 or FAST_READ 0x0B
//   with 8 dummy clocks) and streams every received byte to a BRAM write port.
//   SCK idles high (mode 3); MOSI changes on falling SCK, MISO is sampled on
//   rising SCK. SCK half-period is CLK_DIV clk cycles; CS# is held high for at
//   least CS_HIGH_CYC cycles between transactions.
//   Ports:
//     clk   system clock
//     rst   asynchronous reset, active high
//     bus   spi_flash_block_reader_if.master (request, BRAM port, SPI wires)
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | CS# high, waiting for read_stb
//   ST_CMD     | shifting out the 8-bit command
//   ST_ADDR    | shifting out the 24-bit address
//   ST_DUMMY   | 8 dummy clocks (FAST_READ only), MOSI high
//   ST_DATA    | receiving bytes, one BRAM write per byte
//   ST_LAST    | last byte being written; SCK parked high
//   ST_CS_HIGH | CS# high recovery time, busy still asserted
module spi_flash_block_reader #(
  parameter int BLOCK_SIZE  = 512,
  parameter int BRAM_AW     = 9,
  parameter int CLK_DIV     = 1,
  parameter int FAST_READ   = 0,
  parameter int CS_HIGH_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  spi_flash_block_reader_if.master bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CSH_W = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;
  localparam logic [DIV_W-1:0]   DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [CSH_W-1:0]   CSH_RELOAD = CSH_W'(CS_HIGH_CYC - 1);
  localparam logic [BRAM_AW:0]   BLK_LEN    = (BRAM_AW+1)'(BLOCK_SIZE);
  localparam logic [7:0]         READ_CMD   = (FAST_READ != 0) ? 8'h0B : 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_LAST,
    ST_CS_HIGH
  } state_t;

  state_t             state, state_d;
  logic               sck, sck_d;
  logic               cs_n, cs_n_d;
  logic               mosi, mosi_d;
  logic               busy, busy_d;
  logic [DIV_W-1:0]   div_cnt, div_d;
  logic [4:0]         bit_cnt, bit_d;
  logic [CSH_W-1:0]   csh_cnt, csh_d;
  logic [BRAM_AW-1:0] byte_idx, idx_d;
  logic [BRAM_AW-1:0] last_idx, last_d;
  logic [31:0]        sh_out, sh_out_d;
  logic [6:0]         sh_in, sh_in_d;
  logic               wr_stb, wr_stb_d;
  logic [BRAM_AW-1:0] wr_addr, wr_addr_d;
  logic [7:0]         wr_data, wr_data_d;
  logic               done_stb, done_d;
  logic [BRAM_AW:0]   eff_len;

  // Zero or oversize lengths clamp to a full block.
  assign eff_len = (bus.read_len == '0 || bus.read_len > BLK_LEN) ? BLK_LEN : bus.read_len;

  always_comb begin
    state_d   = state;
    sck_d     = sck;
    cs_n_d    = cs_n;
    mosi_d    = mosi;
    busy_d    = busy;
    div_d     = div_cnt;
    bit_d     = bit_cnt;
    csh_d     = csh_cnt;
    idx_d     = byte_idx;
    last_d    = last_idx;
    sh_out_d  = sh_out;
    sh_in_d   = sh_in;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    done_d    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.read_stb) begin
          cs_n_d   = 1'b0;
          busy_d   = 1'b1;
          sh_out_d = {READ_CMD, bus.read_addr};
          last_d   = BRAM_AW'(eff_len - 1'b1);
          idx_d    = '0;
          bit_d    = 5'd7;
          div_d    = DIV_RELOAD;
          sck_d    = 1'b1;
          mosi_d   = 1'b1;
          state_d  = ST_CMD;
        end
      end

      ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
        if (div_cnt != '0) begin
          div_d = div_cnt - 1'b1;
        end else begin
          div_d = DIV_RELOAD;
          sck_d = ~sck;
          if (sck) begin
            // falling edge: present next command/address bit, MOSI idles high afterwards
            if (state == ST_CMD || state == ST_ADDR) begin
              mosi_d   = sh_out[31];
              sh_out_d = {sh_out[30:0], 1'b0};
            end else begin
              mosi_d = 1'b1;
            end
          end else begin
            // rising edge: sample MISO, count bits
            sh_in_d = {sh_in[5:0], bus.spi_miso};
            if (bit_cnt != 5'd0) begin
              bit_d = bit_cnt - 5'd1;
            end else if (state == ST_CMD) begin
              bit_d   = 5'd23;
              state_d = ST_ADDR;
            end else if (state == ST_ADDR) begin
              bit_d   = 5'd7;
              state_d = (FAST_READ != 0) ? ST_DUMMY : ST_DATA;
            end else if (state == ST_DUMMY) begin
              bit_d   = 5'd7;
              state_d = ST_DATA;
            end else begin
              wr_stb_d  = 1'b1;
              wr_data_d = {sh_in, bus.spi_miso};
              wr_addr_d = byte_idx;
              bit_d     = 5'd7;
              if (byte_idx == last_idx) begin
                // SCK stays high from here: ST_LAST does not toggle it
                state_d = ST_LAST;
              end else begin
                idx_d = byte_idx + 1'b1;
              end
            end
          end
        end
      end

      ST_LAST: begin
        cs_n_d  = 1'b1;
        mosi_d  = 1'b1;
        done_d  = 1'b1;
        csh_d   = CSH_RELOAD;
        state_d = ST_CS_HIGH;
      end

      ST_CS_HIGH: begin
        if (csh_cnt == '0) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          csh_d = csh_cnt - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sck_d   = 1'b1;
        mosi_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sck      <= 1'b1;
      cs_n     <= 1'b1;
      mosi     <= 1'b1;
      busy     <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      csh_cnt  <= '0;
      byte_idx <= '0;
      last_idx <= '0;
      sh_out   <= '0;
      sh_in    <= '0;
      wr_stb   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done_stb <= 1'b0;
    end else begin
      state    <= state_d;
      sck      <= sck_d;
      cs_n     <= cs_n_d;
      mosi     <= mosi_d;
      busy     <= busy_d;
      div_cnt  <= div_d;
      bit_cnt  <= bit_d;
      csh_cnt  <= csh_d;
      byte_idx <= idx_d;
      last_idx <= last_d;
      sh_out   <= sh_out_d;
      sh_in    <= sh_in_d;
      wr_stb   <= wr_stb_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      done_stb <= done_d;
    end
  end

  assign bus.busy            = busy;
  assign bus.read_done_stb   = done_stb;
  assign bus.write_bram_stb  = wr_stb;
  assign bus.write_bram_addr = wr_addr;
  assign bus.write_bram_data = wr_data;
  assign bus.spi_cs_n        = cs_n;
  assign bus.spi_clk         = sck;
  assign bus.spi_mosi        = mosi;

endmodule

// File: tb/tb_spi_flash_block_reader.sv
// tb_spi_flash_block_reader
//   Two readers side by side: u_a (READ, SCK = clk/2, CS# recovery 2) and
//   u_b (FAST_READ, SCK half-period 3, CS# recovery 4), both with a 16-byte
//   block. A behavioural flash drives a fixed byte pattern starting after the
//   header and puts the inverted bit on MISO while SCK is high.
module tb_spi_flash_block_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_flash_block_reader_if #(.BRAM_AW(4)) bus_a ();
  spi_flash_block_reader_if #(.BRAM_AW(4)) bus_b ();

  spi_flash_block_reader #(
    .BLOCK_SIZE(16), .BRAM_AW(4), .CLK_DIV(1), .FAST_READ(0), .CS_HIGH_CYC(2)
  ) u_a (.clk(clk), .rst(rst), .bus(bus_a));

  spi_flash_block_reader #(
    .BLOCK_SIZE(16), .BRAM_AW(4), .CLK_DIV(3), .FAST_READ(1), .CS_HIGH_CYC(4)
  ) u_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_tests = 0;
  int n_fail  = 0;

  // per-transaction observations, cleared on every CS# fall
  int         wr_cnt [2];
  int         addr_err [2];
  int         done_cnt [2];
  int         rise_cnt [2];
  int         mosi_hi_err [2];
  int         toggles [2];
  int         bad_run [2];
  int         run [2];
  logic [3:0] last_addr [2];
  logic [31:0] hdr [2];
  logic [7:0] cap [2][32];
  // running observations
  int         cs_falls [2];
  int         cs_hi_run [2];
  int         last_cs_hi [2];
  logic       prev_cs [2]  = '{1'b1, 1'b1};
  logic       prev_sck [2] = '{1'b1, 1'b1};
  logic       miso_a, miso_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    case (k)
      0:       return 8'hA5;
      1:       return 8'h5A;
      2:       return 8'hFF;
      3:       return 8'h00;
      default: return 8'(k * 37 + 11);
    endcase
  endfunction

  function automatic logic flash_bit(input int s);
    int h, n;
    logic [7:0] b;
    h = (s == 1) ? 40 : 32;
    n = rise_cnt[s];
    if (n < h) return 1'b0;
    b = exp_byte((n - h) / 8);
    return b[7 - ((n - h) % 8)];
  endfunction

  function automatic int data_errs(input int s, input int n);
    int e = 0;
    for (int k = 0; k < n; k++) if (cap[s][k] !== exp_byte(k)) e++;
    return e;
  endfunction

  task automatic mon(input int s, input logic cs_n, input logic sck, input logic mosi,
                     input logic wstb, input logic [3:0] waddr, input logic [7:0] wdata,
                     input logic dstb, input logic miso_in, output logic miso_out);
    int div;
    div = (s == 1) ? 3 : 1;
    miso_out = miso_in;
    if (!cs_n && prev_cs[s]) begin
      cs_falls[s]++;
      last_cs_hi[s] = cs_hi_run[s];
      wr_cnt[s] = 0; addr_err[s] = 0; done_cnt[s] = 0; rise_cnt[s] = 0;
      mosi_hi_err[s] = 0; toggles[s] = 0; bad_run[s] = 0; run[s] = 0;
      hdr[s] = '0; last_addr[s] = '0;
    end
    if (wstb) begin
      if (waddr != 4'(wr_cnt[s])) addr_err[s]++;
      if (wr_cnt[s] < 32) cap[s][wr_cnt[s]] = wdata;
      last_addr[s] = waddr;
      wr_cnt[s]++;
    end
    if (dstb) done_cnt[s]++;
    if (cs_n) begin
      cs_hi_run[s]++;
      run[s] = 0;
    end else begin
      cs_hi_run[s] = 0;
      if (sck != prev_sck[s]) begin
        toggles[s]++;
        if (run[s] != div) bad_run[s]++;
        run[s] = 1;
        if (sck) begin
          if (rise_cnt[s] < 32) hdr[s] = {hdr[s][30:0], mosi};
          else if (!mosi) mosi_hi_err[s]++;
          rise_cnt[s]++;
          miso_out = ~miso_in;
        end else begin
          miso_out = flash_bit(s);
        end
      end else begin
        run[s]++;
      end
    end
    prev_cs[s]  = cs_n;
    prev_sck[s] = sck;
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, bus_a.spi_cs_n, bus_a.spi_clk, bus_a.spi_mosi, bus_a.write_bram_stb,
        bus_a.write_bram_addr, bus_a.write_bram_data, bus_a.read_done_stb, bus_a.spi_miso, miso_a);
    bus_a.spi_miso = miso_a;
    mon(1, bus_b.spi_cs_n, bus_b.spi_clk, bus_b.spi_mosi, bus_b.write_bram_stb,
        bus_b.write_bram_addr, bus_b.write_bram_data, bus_b.read_done_stb, bus_b.spi_miso, miso_b);
    bus_b.spi_miso = miso_b;
  end

  function automatic logic busy_of(input int s);
    return (s == 0) ? bus_a.busy : bus_b.busy;
  endfunction

  function automatic logic [17:0] outs_a();
    return {bus_a.spi_cs_n, bus_a.spi_clk, bus_a.spi_mosi, bus_a.busy, bus_a.write_bram_stb,
            bus_a.read_done_stb, bus_a.write_bram_addr, bus_a.write_bram_data};
  endfunction

  localparam logic [17:0] RST_OUTS = {6'b111000, 12'h000};

  task automatic drive_stb(input int s, input logic [23:0] addr, input logic [4:0] len);
    if (s == 0) begin
      bus_a.read_addr = addr; bus_a.read_len = len; bus_a.read_stb = 1'b1;
    end else begin
      bus_b.read_addr = addr; bus_b.read_len = len; bus_b.read_stb = 1'b1;
    end
    @(negedge clk);
    bus_a.read_stb = 1'b0;
    bus_b.read_stb = 1'b0;
  endtask

  task automatic start_read(input int s, input logic [23:0] addr, input logic [4:0] len);
    @(negedge clk);
    drive_stb(s, addr, len);
  endtask

  task automatic wait_done(input int s, input string tag);
    int i = 0;
    while (i < 5000 && !(done_cnt[s] > 0 && busy_of(s) == 1'b0)) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'({done_cnt[s] > 0, busy_of(s)}), 32'b10);
  endtask

  int f0;

  initial begin
    rst = 1'b1;
    bus_a.read_stb = 1'b0; bus_a.read_addr = '0; bus_a.read_len = '0;
    bus_b.read_stb = 1'b0; bus_b.read_addr = '0; bus_b.read_len = '0;
    repeat (3) @(negedge clk);
    check("rst_a_outs", 32'(outs_a()), 32'(RST_OUTS));
    check("rst_b_idle", 32'({bus_b.spi_cs_n, bus_b.spi_clk, bus_b.spi_mosi, bus_b.busy}), 32'b1110);
    rst = 1'b0;

    // READ, 4 bytes, SCK = clk/2
    start_read(0, 24'h012345, 5'd4);
    wait_done(0, "t1_done");
    check("t1_header", hdr[0], 32'h03012345);
    check("t1_writes", wr_cnt[0], 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("t1_byte%0d", k), 32'(cap[0][k]), 32'(exp_byte(k)));
    check("t1_addr_order", addr_err[0], 0);
    check("t1_last_addr", 32'(last_addr[0]), 3);
    check("t1_done_cnt", done_cnt[0], 1);
    check("t1_sck_rises", rise_cnt[0], 64);
    check("t1_mosi_idle_hi", mosi_hi_err[0], 0);

    // FAST_READ, 1 byte
    start_read(1, 24'hABCDEF, 5'd1);
    wait_done(1, "t2_done");
    check("t2_header", hdr[1], 32'h0BABCDEF);
    check("t2_sck_rises", rise_cnt[1], 48);
    check("t2_writes", wr_cnt[1], 1);
    check("t2_byte0", 32'(cap[1][0]), 32'h A5);
    check("t2_last_addr", 32'(last_addr[1]), 0);
    check("t2_dummy_mosi_hi", mosi_hi_err[1], 0);

    // length 0 and oversize clamp to the block size
    start_read(0, 24'h000100, 5'd0);
    wait_done(0, "t3a_done");
    check("t3a_writes", wr_cnt[0], 16);
    check("t3a_last_addr", 32'(last_addr[0]), 15);
    check("t3a_data_errs", data_errs(0, 16), 0);
    check("t3a_addr_order", addr_err[0], 0);
    start_read(0, 24'h000100, 5'd21);
    wait_done(0, "t3b_done");
    check("t3b_writes", wr_cnt[0], 16);
    check("t3b_last_addr", 32'(last_addr[0]), 15);
    check("t3b_data_errs", data_errs(0, 16), 0);
    check("t3b_sck_rises", rise_cnt[0], 160);

    // SCK half-period of 3 clocks
    start_read(1, 24'h00AB00, 5'd3);
    wait_done(1, "t4_done");
    check("t4_header", hdr[1], 32'h0B00AB00);
    check("t4_sck_rises", rise_cnt[1], 64);
    check("t4_sck_toggles", toggles[1], 128);
    check("t4_sck_phase_len", bad_run[1], 0);
    check("t4_writes", wr_cnt[1], 3);
    check("t4_data_errs", data_errs(1, 3), 0);

    // start pulses while busy are dropped; back-to-back restart
    f0 = cs_falls[0];
    start_read(0, 24'h000040, 5'd8);
    for (int i = 0; i < 2000 && wr_cnt[0] < 3; i++) @(negedge clk);
    check("t5_reach_data", 32'(wr_cnt[0] >= 3), 1);
    drive_stb(0, 24'hFFFFFF, 5'd2);
    for (int i = 0; i < 2000 && !bus_a.read_done_stb; i++) @(negedge clk);
    check("t5_done_seen", 32'(bus_a.read_done_stb), 1);
    drive_stb(0, 24'hFFFFFF, 5'd2);
    for (int i = 0; i < 100 && bus_a.busy; i++) @(negedge clk);
    check("t5_busy_clear", 32'(bus_a.busy), 0);
    check("t5_writes", wr_cnt[0], 8);
    check("t5_sck_rises", rise_cnt[0], 96);
    check("t5_done_cnt", done_cnt[0], 1);
    check("t5_data_errs", data_errs(0, 8), 0);
    drive_stb(0, 24'h000010, 5'd2);
    wait_done(0, "t5r_done");
    check("t5_cs_falls", cs_falls[0] - f0, 2);
    check("t5_cs_high_min", 32'(last_cs_hi[0] >= 2), 1);
    check("t5r_writes", wr_cnt[0], 2);
    check("t5r_data_errs", data_errs(0, 2), 0);

    // reset in the middle of ADDR
    start_read(0, 24'h000000, 5'd8);
    for (int i = 0; i < 2000 && rise_cnt[0] < 20; i++) @(negedge clk);
    check("t6a_reach_addr", 32'(rise_cnt[0] >= 20), 1);
    rst = 1'b1;
    #1;
    check("t6a_rst_outs", 32'(outs_a()), 32'(RST_OUTS));
    @(negedge clk);
    rst = 1'b0;
    start_read(0, 24'h000200, 5'd3);
    wait_done(0, "t6a_done");
    check("t6a_writes", wr_cnt[0], 3);
    check("t6a_addr_order", addr_err[0], 0);
    check("t6a_data_errs", data_errs(0, 3), 0);

    // reset in the middle of DATA
    start_read(0, 24'h000000, 5'd8);
    for (int i = 0; i < 2000 && wr_cnt[0] < 2; i++) @(negedge clk);
    check("t6b_reach_data", 32'(wr_cnt[0] >= 2), 1);
    rst = 1'b1;
    #1;
    check("t6b_rst_outs", 32'(outs_a()), 32'(RST_OUTS));
    @(negedge clk);
    rst = 1'b0;
    start_read(0, 24'h000300, 5'd5);
    wait_done(0, "t6b_done");
    check("t6b_writes", wr_cnt[0], 5);
    check("t6b_last_addr", 32'(last_addr[0]), 4);
    check("t6b_addr_order", addr_err[0], 0);
    check("t6b_data_errs", data_errs(0, 5), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
